// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial converter with start/last framing and idle gap
// Defining BIT_SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             start,
  output logic             din,
  output logic             last,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_PARITY} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;
`endif

  // Where a frame goes once its final bit has been emitted.
  localparam state_e ST_AFTER = (GAP > 0) ? ST_GAP : ST_IDLE;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             din_q, din_d;
  logic             start_q, start_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign in_ready = (state_q == ST_IDLE);
  assign start    = start_q;
  assign din      = din_q;
  assign last     = last_q;
  assign busy     = busy_q;

  // Outputs are computed for the next cycle so they can all be registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    sh_d    = sh_q;
    din_d   = 1'b0;
    start_d = 1'b0;
    last_d  = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sh_d    = advance(in_data);
          din_d   = head_bit(in_data);
          start_d = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = ST_PARITY;
          din_d   = par_q;
          last_d  = 1'b1;
`else
          state_d = ST_AFTER;
          gcnt_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
          din_d = head_bit(sh_q);
          sh_d  = advance(sh_q);
`ifndef BIT_SERIALIZER_PARITY_EN
          last_d = (cnt_d == CNT_LAST);
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        state_d = ST_AFTER;
        gcnt_d  = '0;
      end
`endif
      ST_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      sh_q    <= '0;
      din_q   <= 1'b0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      sh_q    <= sh_d;
      din_q   <= din_d;
      start_q <= start_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits (2..32).
REQ-002 Parameter: MSB_FIRST, 1, shift order; 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 Parameter: GAP, 0, idle cycles inserted after each frame (0..15).
REQ-004 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port: rst  input  1  reset; synchronous and active-high.
REQ-006 Port: in_data  input  WIDTH  parallel word to serialize.
REQ-007 Port: in_valid  input  1  in_data is valid.
REQ-008 Port: in_ready  output  1  block can accept a word this cycle.
REQ-009 Port: start  output  1  one-cycle pulse marking the first serial bit of a frame; feeds the downstream start input.
REQ-010 Port: din  output  1  serial bit stream; feeds the downstream din input.
REQ-011 Port: last  output  1  high on the final bit of a frame (data or parity).
REQ-012 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, PARITY (present only with PARITY_EN), and GAP.
REQ-014 A transfer SHALL occur when in_valid && in_ready on a rising edge; in_ready SHALL be high only in IDLE (combinational from state).
REQ-015 On transfer, the word SHALL be latched into a WIDTH-bit shift register; in_data is don't-care afterwards.
REQ-016 Latency: the first serial bit SHALL appear on din in the cycle after the transfer edge, with start = 1 in that same cycle only.
REQ-017 In SHIFT, exactly one bit per cycle for WIDTH consecutive cycles; order per MSB_FIRST.
REQ-018 A bit counter SHALL count 0..WIDTH-1 and SHALL NOT wrap within a frame; on the last data bit the FSM SHALL go to PARITY if enabled, else GAP if GAP > 0, else IDLE.
REQ-019 last SHALL be high for exactly one cycle per frame, on the final bit emitted.
REQ-020 In GAP, din = 0, start = 0, and the FSM SHALL remain for exactly GAP cycles, then enter IDLE.
REQ-021 In IDLE, din = 0, start = 0, last = 0, busy = 0.
REQ-022 With GAP = 0 and in_valid held high, frames SHALL be separated by exactly one IDLE cycle; the throughput of a frame is WIDTH (+1 parity) + GAP + 1 cycles.
REQ-023 in_valid asserted outside IDLE SHALL be ignored (no capture, no corruption of the frame in progress); the source holds it until in_ready.
REQ-024 All outputs except in_ready SHALL be registered.

Reset
REQ-025 When rst = 1 on a rising edge, the FSM SHALL enter IDLE, counters and shift register SHALL clear, and start, din, last and busy SHALL be 0 from the next cycle.
REQ-026 rst asserted mid-frame SHALL abort the frame immediately, with no partial bits, start or last emitted after the edge; in_ready SHALL be 1 in the cycle after rst deasserts.
REQ-027 rst SHALL take priority over a simultaneous transfer; the word SHALL be dropped.

Configuration
REQ-028 Macro BIT_SERIALIZER_PARITY_EN: when defined, one even-parity bit (XOR of the WIDTH data bits) SHALL follow the last data bit in state PARITY, with last on the parity bit. When undefined, the PARITY state and logic SHALL be absent and last SHALL mark the final data bit.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, no parity: send 0xA5 -> din = 1,0,1,0,0,1,0,1 in cycles T+1..T+8; start at T+1; last at T+8; in_ready at T+9.
REQ-030 MSB_FIRST=0: send 0x01 -> din = 1 at T+1, then 0 for T+2..T+8.
REQ-031 PARITY_EN defined: send 0x07 -> 8 data bits then parity bit 1 at T+9 with last = 1; send 0x03 -> parity bit 0.
REQ-032 GAP=3, in_valid held high with 0xFF, 0x00: second start exactly WIDTH+3+1 cycles after the first start; din = 0 during the gap.
REQ-033 rst pulsed at the 4th bit of 0xFF -> din = 0, busy = 0 from the next cycle; no last pulse; next word serializes cleanly.
REQ-034 in_valid toggled with new data while busy -> the in-flight word is unaltered; the new word is accepted only when in_ready = 1.
